mem_port_responder: RTL and testbench

- Memory-side responder for the multicycle control FSM's memory requests: instruction fetch, load-byte/word read, store write.
- Accepts one request at a time over a valid/ready handshake and drives the single-port synchronous block RAM with a configurable number of wait states.
- Returns a one-cycle response pulse carrying read data, so the control FSM stalls in its fetch, read and write states until the response arrives.
- Sits between controlFSM/datapath and the RAM macro.

---
 rtl/mem_port_responder_if.sv | 39 +++
 rtl/mem_port_responder.sv | 133 +++++++++++++
 tb/tb_mem_port_responder.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_responder_if.sv
// Request/response and RAM-side signal bundle for mem_port_responder.
// resp_err exists only when MEM_BUS_ERR_EN is defined.
interface mem_port_responder_if #(
  parameter int WIDTH     = 16,
  parameter int ADDR_BITS = 16
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_write;
  logic                 req_fetch;
  logic [ADDR_BITS-1:0] req_addr;
  logic [WIDTH-1:0]     req_wdata;
  logic                 resp_valid;
  logic                 resp_fetch;
  logic [WIDTH-1:0]     resp_rdata;
`ifdef MEM_BUS_ERR_EN
  logic                 resp_err;
`endif
  logic [ADDR_BITS-1:0] ram_addr;
  logic [WIDTH-1:0]     ram_wdata;
  logic                 ram_wren;
  logic [WIDTH-1:0]     ram_rdata;

  modport slave (
    input  req_valid, req_write, req_fetch, req_addr, req_wdata, ram_rdata,
    output req_ready, resp_valid, resp_fetch, resp_rdata, ram_addr, ram_wdata, ram_wren
`ifdef MEM_BUS_ERR_EN
    , output resp_err
`endif
  );

  modport master (
    output req_valid, req_write, req_fetch, req_addr, req_wdata, ram_rdata,
    input  req_ready, resp_valid, resp_fetch, resp_rdata, ram_addr, ram_wdata, ram_wren
`ifdef MEM_BUS_ERR_EN
    , input resp_err
`endif
  );
endinterface

// File: rtl/mem_port_responder.sv
// Single-outstanding memory responder driving a synchronous RAM with WAIT_STATES extra cycles.
// Define MEM_BUS_ERR_EN to add ADDR_LIMIT and resp_err (out-of-range requests answer in one cycle).
module mem_port_responder #(
  parameter int WIDTH       = 16,
  parameter int ADDR_BITS   = 16,
  parameter int WAIT_STATES = 2
`ifdef MEM_BUS_ERR_EN
  , parameter logic [ADDR_BITS-1:0] ADDR_LIMIT = ADDR_BITS'(16'h8000)
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_port_responder_if.slave  bus
);

  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
    $error("mem_port_responder: WAIT_STATES must be within 0..15");
  end

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;

  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]     wdata_q, wdata_d;
  logic                 write_q, write_d;
  logic                 fetch_q, fetch_d;
  logic [WIDTH-1:0]     rdata_q, rdata_d;
`ifdef MEM_BUS_ERR_EN
  logic                 err_q, err_d;
`endif

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    write_d         = write_q;
    fetch_d         = fetch_q;
    rdata_d         = rdata_q;
`ifdef MEM_BUS_ERR_EN
    err_d           = err_q;
    bus.resp_err    = 1'b0;
`endif
    bus.req_ready   = 1'b0;
    bus.resp_valid  = 1'b0;
    bus.resp_fetch  = 1'b0;
    bus.ram_wren    = 1'b0;

    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          write_d = bus.req_write;
          fetch_d = bus.req_fetch & ~bus.req_write;
          cnt_d   = WAIT_LOAD;
`ifdef MEM_BUS_ERR_EN
          // Out-of-range requests never touch the RAM, so its address/data registers keep their values.
          if (bus.req_addr >= ADDR_LIMIT) begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = RESP;
          end else begin
            err_d   = 1'b0;
            addr_d  = bus.req_addr;
            wdata_d = bus.req_wdata;
            state_d = ACCESS;
          end
`else
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          state_d = ACCESS;
`endif
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          bus.ram_wren = write_q;
          state_d      = write_q ? RESP : CAPTURE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      CAPTURE: begin
        rdata_d = bus.ram_rdata;
        state_d = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_fetch = fetch_q;
`ifdef MEM_BUS_ERR_EN
        bus.resp_err   = err_q;
`endif
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.ram_addr   = addr_q;
  assign bus.ram_wdata  = wdata_q;
  assign bus.resp_rdata = rdata_q;

  // ram_wren decodes from state_q, so the async reset drops it without a clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      fetch_q <= 1'b0;
      rdata_q <= '0;
`ifdef MEM_BUS_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      fetch_q <= fetch_d;
      rdata_q <= rdata_d;
`ifdef MEM_BUS_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_port_responder.sv
// Randomized + directed bench for mem_port_responder against a transaction-timeline model.
// Exercises the MEM_BUS_ERR_EN behaviour too when that macro is defined.
module tb_mem_port_responder;
  localparam int W  = 16;
  localparam int AB = 16;
  localparam int WS = 2;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_responder_if #(.WIDTH(W), .ADDR_BITS(AB)) bus0 ();
  mem_port_responder_if #(.WIDTH(W), .ADDR_BITS(AB)) bus1 ();

  mem_port_responder #(.WIDTH(W), .ADDR_BITS(AB), .WAIT_STATES(WS)) u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus0)
  );

  mem_port_responder #(.WIDTH(W), .ADDR_BITS(AB), .WAIT_STATES(0)) u_dut_ws0 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus1)
  );

  // Initial RAM image: a fixed hash of the address, with 0x0010 preloaded to BEEF.
  function automatic logic [15:0] init_val(input logic [15:0] a);
    logic [15:0] p;
    if (a == 16'h0010) return 16'hBEEF;
    p = a * 16'h9E37;
    return p ^ 16'h5A5A;
  endfunction

  // RAM stand-ins with 1-cycle registered read.
  logic [15:0] ram0 [0:65535];
  bit          wr0  [0:65535];
  logic [15:0] ram1 [0:255];
  bit          wr1  [0:255];

  always @(posedge clk) begin
    if (bus0.ram_wren) begin
      ram0[bus0.ram_addr] <= bus0.ram_wdata;
      wr0[bus0.ram_addr]  <= 1'b1;
    end
    bus0.ram_rdata <= wr0[bus0.ram_addr] ? ram0[bus0.ram_addr] : init_val(bus0.ram_addr);
  end

  always @(posedge clk) begin
    if (bus1.ram_wren) begin
      ram1[bus1.ram_addr[7:0]] <= bus1.ram_wdata;
      wr1[bus1.ram_addr[7:0]]  <= 1'b1;
    end
    bus1.ram_rdata <= wr1[bus1.ram_addr[7:0]] ? ram1[bus1.ram_addr[7:0]]
                                               : init_val({8'h00, bus1.ram_addr[7:0]});
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Reference model: one outstanding transaction described by its accept cycle.
  logic [15:0] ref_mem [int];
  bit          pend = 1'b0;
  int          t_acc, t_resp;
  int          next_ok = 0;
  bit          t_w, t_f, t_err;
  logic [15:0] t_a, t_d, t_rd;
  logic [15:0] exp_rdata = '0;
  logic [15:0] last_addr = '0;
  int          resp_log [$];

  initial begin
    int  c;
    bit  exp_ready, exp_valid, exp_wren;
    t_acc = 0; t_resp = 0; t_w = 0; t_f = 0; t_err = 0; t_a = '0; t_d = '0; t_rd = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        pend      = 1'b0;
        next_ok   = cyc;
        exp_rdata = '0;
        last_addr = '0;
      end else begin
        c         = cyc;
        exp_ready = (c >= next_ok);
        exp_valid = pend && (c == t_resp);
        exp_wren  = pend && t_w && !t_err && (c == t_acc + WS + 1);
        if (exp_valid && t_err) exp_rdata = '0;
        else if (exp_valid && !t_w) exp_rdata = t_rd;
        chk("req_ready",  bus0.req_ready,  exp_ready);
        chk("resp_valid", bus0.resp_valid, exp_valid);
        chk("resp_fetch", bus0.resp_fetch, exp_valid && t_f && !t_w);
        chk("resp_rdata", bus0.resp_rdata, exp_rdata);
        chk("ram_wren",   bus0.ram_wren,   exp_wren);
        if (exp_wren) begin
          chk("ram_wdata", bus0.ram_wdata, t_d);
          ref_mem[int'(t_a)] = t_d;
        end
        if (pend && !t_err && c >= t_acc + 1 && c <= t_acc + WS + 1)
          chk("ram_addr", bus0.ram_addr, t_a);
`ifdef MEM_BUS_ERR_EN
        chk("resp_err", bus0.resp_err, exp_valid && t_err);
        if (exp_valid && t_err) chk("ram_addr_hold", bus0.ram_addr, last_addr);
`endif
        if (bus0.resp_valid) resp_log.push_back(c);
        if (exp_valid) pend = 1'b0;
        if (bus0.req_valid && exp_ready) begin
          pend  = 1'b1;
          t_acc = c;
          t_w   = bus0.req_write;
          t_f   = bus0.req_fetch;
          t_a   = bus0.req_addr;
          t_d   = bus0.req_wdata;
          t_err = 1'b0;
`ifdef MEM_BUS_ERR_EN
          t_err = (bus0.req_addr >= 16'h8000);
`endif
          t_rd  = ref_mem.exists(int'(t_a)) ? ref_mem[int'(t_a)] : init_val(t_a);
          if (t_err) begin
            t_resp = c + 1;       next_ok = c + 2;
          end else if (t_w) begin
            t_resp = c + WS + 2;  next_ok = c + WS + 3;  last_addr = t_a;
          end else begin
            t_resp = c + WS + 3;  next_ok = c + WS + 4;  last_addr = t_a;
          end
        end
      end
    end
  end

  // Drive one request on bus0 and report latencies relative to the accept cycle.
  task automatic issue(input logic w, input logic f, input logic [15:0] a, input logic [15:0] d,
                       output int lat, output int wlat, output logic [15:0] rd,
                       output logic rf, output logic re);
    int acc, n;
    lat = -1; wlat = -1; rd = '0; rf = 1'b0; re = 1'b0;
    @(posedge clk); #1;
    bus0.req_valid = 1'b1; bus0.req_write = w; bus0.req_fetch = f;
    bus0.req_addr  = a;    bus0.req_wdata = d;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus0.req_ready && n < 20);
    acc = cyc;
    @(posedge clk); #1;
    bus0.req_valid = 1'b0;
    bus0.req_addr  = 16'($urandom);
    bus0.req_wdata = 16'($urandom);
    n = 0;
    while (lat < 0 && n < 40) begin
      @(negedge clk); n++;
      if (bus0.ram_wren) wlat = cyc - acc;
      if (bus0.resp_valid) begin
        lat = cyc - acc;
        rd  = bus0.resp_rdata;
        rf  = bus0.resp_fetch;
`ifdef MEM_BUS_ERR_EN
        re  = bus0.resp_err;
`endif
      end
    end
  endtask

  initial begin
    int          lat, wlat, n, nacc, acc1, b2b_diff, b2b_gap;
    int          accs [2];
    logic [15:0] rd, off, base;
    logic        rf, re;

    bus0.req_valid = 0; bus0.req_write = 0; bus0.req_fetch = 0; bus0.req_addr = '0; bus0.req_wdata = '0;
    bus1.req_valid = 0; bus1.req_write = 0; bus1.req_fetch = 0; bus1.req_addr = '0; bus1.req_wdata = '0;
    accs[0] = 0; accs[1] = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready",  bus0.req_ready,  1);
    chk("rst_resp_valid", bus0.resp_valid, 0);
    chk("rst_resp_rdata", bus0.resp_rdata, 0);
    chk("rst_ram_addr",   bus0.ram_addr,   0);
    chk("rst_ram_wdata",  bus0.ram_wdata,  0);
    chk("rst_ram_wren",   bus0.ram_wren,   0);
    #2 reset = 1'b1;

    issue(1'b0, 1'b1, 16'h0010, 16'h0000, lat, wlat, rd, rf, re);
    chk("rd_latency", lat, 5);
    chk("rd_data",    rd,  16'hBEEF);
    chk("rd_fetch",   rf,  1);

    issue(1'b1, 1'b1, 16'h0020, 16'h1234, lat, wlat, rd, rf, re);
    chk("wr_wren_cycle", wlat, 3);
    chk("wr_latency",    lat,  4);
    chk("wr_fetch",      rf,   0);
    chk("wr_keeps_rdata", bus0.resp_rdata, 16'hBEEF);

    issue(1'b0, 1'b0, 16'h0020, 16'h0000, lat, wlat, rd, rf, re);
    chk("rd_after_wr", rd, 16'h1234);

    // Back-to-back: req_valid held high across two reads.
    resp_log.delete();
    @(posedge clk); #1;
    bus0.req_valid = 1'b1; bus0.req_write = 1'b0; bus0.req_fetch = 1'b0; bus0.req_addr = 16'h0010;
    n = 0; nacc = 0;
    while (nacc < 2 && n < 40) begin
      @(negedge clk); n++;
      if (bus0.req_ready) begin accs[nacc] = cyc; nacc++; end
    end
    @(posedge clk); #1;
    bus0.req_valid = 1'b0;
    n = 0;
    while (resp_log.size() < 2 && n < 40) begin @(negedge clk); n++; end
    chk("b2b_accepts", nacc, 2);
    b2b_diff = (resp_log.size() >= 2) ? resp_log[1] - resp_log[0] : -1;
    b2b_gap  = (resp_log.size() >= 1) ? accs[1] - resp_log[0] : -1;
    chk("b2b_resp_spacing", b2b_diff, 6);
    chk("b2b_idle_gap",     b2b_gap,  1);

    // WAIT_STATES = 0 instance.
    @(posedge clk); #1;
    bus1.req_valid = 1'b1; bus1.req_addr = 16'h0001;
    @(negedge clk);
    chk("ws0_ready", bus1.req_ready, 1);
    acc1 = cyc;
    @(posedge clk); #1;
    bus1.req_valid = 1'b0;
    n = 0; lat = -1; rd = '0;
    while (lat < 0 && n < 20) begin
      @(negedge clk); n++;
      if (bus1.resp_valid) begin lat = cyc - acc1; rd = bus1.resp_rdata; end
    end
    chk("ws0_latency", lat, 3);
    chk("ws0_data",    rd,  16'hC46D);

`ifdef MEM_BUS_ERR_EN
    issue(1'b1, 1'b0, 16'h9000, 16'hDEAD, lat, wlat, rd, rf, re);
    chk("err_latency", lat,  1);
    chk("err_no_wren", wlat, -1);
    chk("err_flag",    re,   1);
    chk("err_rdata",   rd,   0);
    issue(1'b0, 1'b0, 16'h7FFF, 16'h0000, lat, wlat, rd, rf, re);
    chk("inrange_err", re,  0);
    chk("inrange_lat", lat, 5);
`endif

    // Reset during the final ACCESS cycle of a write.
    @(posedge clk); #1;
    bus0.req_valid = 1'b1; bus0.req_write = 1'b1; bus0.req_addr = 16'h0030; bus0.req_wdata = 16'h5555;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus0.req_ready && n < 20);
    @(posedge clk); #1;
    bus0.req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    chk("mid_wren_before", bus0.ram_wren, 1);
    reset = 1'b0;
    #1;
    chk("mid_wren_drop",  bus0.ram_wren,  0);
    chk("mid_ready",      bus0.req_ready, 1);
    chk("mid_resp_valid", bus0.resp_valid, 0);
    resp_log.delete();
    @(negedge clk); #2 reset = 1'b1;
    repeat (10) @(negedge clk);
    chk("mid_no_resp",    resp_log.size(), 0);
    chk("mid_rdata_zero", bus0.resp_rdata, 0);
    issue(1'b0, 1'b0, 16'h0030, 16'h0000, lat, wlat, rd, rf, re);
    chk("mid_write_dropped", rd, init_val(16'h0030));

    // Randomized traffic; fields keep changing after acceptance.
    for (int i = 0; i < 2500; i++) begin
      @(posedge clk); #1;
      off = 16'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0:       base = 16'h0000;
        1:       base = 16'h7FF8;
        2:       base = 16'hFFF8;
        default: base = 16'h0010;
      endcase
      bus0.req_valid = ($urandom_range(0, 9) < 6);
      bus0.req_write = 1'($urandom_range(0, 1));
      bus0.req_fetch = 1'($urandom_range(0, 1));
      bus0.req_addr  = base + off;
      bus0.req_wdata = 16'($urandom);
    end
    @(posedge clk); #1;
    bus0.req_valid = 1'b0;
    repeat (12) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
